// File: rtl/ann_pkg.sv
// ann_pkg: shared widths, Q8.24 saturation bounds and trainer state encoding
package ann_pkg;
   localparam int DWIDTH = 32;
   localparam int FRAC = 24;
   localparam logic signed [2*DWIDTH-1:0] SAT_HI = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [2*DWIDTH-1:0] SAT_LO = -64'sh0000_0000_8000_0000;
   typedef enum logic [2:0] {IDLE, FEED, WAIT, UPDATE, DONE} state_t;
endpackage

// File: rtl/perceptron_wupd.sv
// perceptron_wupd: one learning-rule step w +/- lr*x at full width, saturated to 32 bits
module perceptron_wupd
   import ann_pkg::*;
(
   input  logic [DWIDTH-1:0] w,
   input  logic [DWIDTH-1:0] lr,
   input  logic [DWIDTH-1:0] x,
   input  logic              add,
   input  logic              en,
   output logic [DWIDTH-1:0] y
);
   logic signed [2*DWIDTH-1:0] wext, prod, sum;
   always_comb begin
      wext = $signed({{DWIDTH{w[DWIDTH-1]}}, w});
      prod = $signed({{DWIDTH{lr[DWIDTH-1]}}, lr}) * $signed({{DWIDTH{x[DWIDTH-1]}}, x});
      sum = add ? wext + prod : wext - prod;
      y = !en ? w : sum > SAT_HI ? SAT_HI[DWIDTH-1:0] : sum < SAT_LO ? SAT_LO[DWIDTH-1:0] : sum[DWIDTH-1:0];
   end
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: streams samples into a perceptron and applies the learning rule until an error-free epoch
module perceptron_trainer
   import ann_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DWIDTH-1:0] init_wa,
   input  logic [DWIDTH-1:0] init_wb,
   input  logic [DWIDTH-1:0] init_bias,
   input  logic [DWIDTH-1:0] lr,
   input  logic [15:0]       n_samples,
   input  logic [15:0]       max_epochs,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DWIDTH-1:0] s_a,
   input  logic [DWIDTH-1:0] s_b,
   input  logic              s_t,
   output logic [DWIDTH-1:0] A,
   output logic [DWIDTH-1:0] B,
   output logic [DWIDTH-1:0] wa,
   output logic [DWIDTH-1:0] wb,
   output logic [DWIDTH-1:0] bias,
   input  logic [DWIDTH-1:0] p_out,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [15:0]       epoch_cnt,
   output logic [15:0]       err_cnt
);
   state_t state, nxt;
   logic [DWIDTH-1:0] lr_q, ya, yb, yc;
   logic [15:0] n_q, max_q, scnt, err_nxt;
   logic [3:0] wcnt;
   logic t_q, pred, miss, last_wait, last_smp, last_ep;
   assign miss = pred != t_q;
   assign last_wait = wcnt == 4'(LAT - 1);
   assign last_smp = scnt == n_q - 16'd1;
   assign last_ep = epoch_cnt == max_q - 16'd1;
   assign err_nxt = miss && err_cnt != 16'hFFFF ? err_cnt + 16'd1 : err_cnt;
   // the target sign selects add/subtract; bias sees a constant feature of 1
   perceptron_wupd u_wa (.w(wa), .lr(lr_q), .x(A), .add(t_q), .en(miss), .y(ya));
   perceptron_wupd u_wb (.w(wb), .lr(lr_q), .x(B), .add(t_q), .en(miss), .y(yb));
   perceptron_wupd u_bias (.w(bias), .lr(lr_q), .x(32'd1), .add(t_q), .en(miss), .y(yc));
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: if (start) nxt = (n_samples == 16'd0 || max_epochs == 16'd0) ? DONE : FEED;
         FEED: if (s_valid) nxt = WAIT;
         WAIT: if (last_wait) nxt = UPDATE;
         UPDATE: nxt = last_smp && (err_nxt == 16'd0 || last_ep) ? DONE : FEED;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      busy = state == FEED || state == WAIT || state == UPDATE;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {A, B, wa, wb, bias, lr_q} <= '0;
         {n_q, max_q, scnt, epoch_cnt, err_cnt} <= '0;
         wcnt <= '0;
         {t_q, pred, s_ready, converged} <= '0;
      end else begin
         s_ready <= nxt == FEED;
         case (state)
            IDLE, DONE: if (start) begin
               wa <= init_wa;
               wb <= init_wb;
               bias <= init_bias;
               lr_q <= lr;
               n_q <= n_samples;
               max_q <= max_epochs;
               {scnt, epoch_cnt, err_cnt} <= '0;
               converged <= 1'b0;
            end
            FEED: if (s_valid) begin
               A <= s_a;
               B <= s_b;
               t_q <= s_t;
               wcnt <= '0;
            end
            WAIT: begin
               wcnt <= wcnt + 4'd1;
               if (last_wait) pred <= $signed(p_out) > 32'sd0;
            end
            UPDATE: begin
               wa <= ya;
               wb <= yb;
               bias <= yc;
               err_cnt <= err_nxt;
               if (!last_smp) scnt <= scnt + 16'd1;
               else if (err_nxt == 16'd0) converged <= 1'b1;
               else if (!last_ep) begin
                  epoch_cnt <= epoch_cnt + 16'd1;
                  err_cnt <= '0;
                  scnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed vectors with hand-computed expectations for perceptron_trainer
module tb_perceptron_trainer;
   localparam int LAT = 2;
   logic clk = 1'b0;
   logic rst, start, s_valid, s_t, s_ready, busy, done, converged, use_model;
   logic [31:0] init_wa, init_wb, init_bias, lr, s_a, s_b, A, B, wa, wb, bias, p_out, p_force;
   logic [15:0] n_samples, max_epochs, epoch_cnt, err_cnt;
   logic [31:0] xa [4];
   logic [31:0] xb [4];
   logic xt [4];
   longint acc;
   int nerr = 0, nchk = 0, cyc;
   always #5 clk = ~clk;
   perceptron_trainer #(.LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .init_wa(init_wa), .init_wb(init_wb),
      .init_bias(init_bias), .lr(lr), .n_samples(n_samples), .max_epochs(max_epochs),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_t(s_t),
      .A(A), .B(B), .wa(wa), .wb(wb), .bias(bias), .p_out(p_out), .busy(busy),
      .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
   );
   // behavioural perceptron: sign of wa*A + wb*B + bias, or a forced value
   always_comb begin
      acc = longint'($signed(wa)) * longint'($signed(A)) + longint'($signed(wb)) * longint'($signed(B)) + longint'($signed(bias));
      p_out = use_model ? (acc > 0 ? 32'd1 : 32'hFFFF_FFFF) : p_force;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic go(input logic [31:0] iwa, iwb, ib, l, input logic [15:0] n, m);
      init_wa = iwa;
      init_wb = iwb;
      init_bias = ib;
      lr = l;
      n_samples = n;
      max_epochs = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   task automatic send(input logic [31:0] a, b, input logic t, input int gap);
      s_valid = 1'b0;
      repeat (gap) tick();
      s_valid = 1'b1;
      s_a = a;
      s_b = b;
      s_t = t;
      for (int i = 0; i < 100 && !s_ready && !done; i++) tick();
      if (!done) check("send_ready", {31'd0, s_ready}, 32'd1);
      if (s_ready) tick();
      s_valid = 1'b0;
   endtask
   task automatic wait_done(output int c);
      c = 1;
      while (!done && c < 3000) begin
         tick();
         c++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask
   task automatic train(input bit gaps, input string tag);
      use_model = 1'b1;
      go(32'd0, 32'd0, 32'd0, 32'h0100_0000, 16'd4, 16'd20);
      for (int e = 0; e < 20 && !done; e++)
         for (int k = 0; k < 4; k++)
            if (!done) begin
               send(xa[k], xb[k], xt[k], gaps ? (e * 4 + k) % 6 : 0);
               if (gaps && e == 0 && k == 0) begin
                  go(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h0200_0000, 16'd0, 16'd0);
                  check({tag, "_start_ignored"}, {31'd0, busy}, 32'd1);
               end
            end
      wait_done(cyc);
      check({tag, "_conv"}, {31'd0, converged}, 32'd1);
      check({tag, "_epoch"}, {16'd0, epoch_cnt}, 32'd5);
      check({tag, "_err"}, {16'd0, err_cnt}, 32'd0);
      check({tag, "_wa"}, wa, 32'h0200_0000);
      check({tag, "_wb"}, wb, 32'h0100_0000);
      check({tag, "_bias"}, bias, 32'hFE00_0000);
   endtask
   initial begin
      xa = '{32'd0, 32'd0, 32'd1, 32'd1};
      xb = '{32'd0, 32'd1, 32'd0, 32'd1};
      xt = '{1'b0, 1'b0, 1'b0, 1'b1};
      rst = 1'b1;
      start = 1'b0;
      s_valid = 1'b0;
      s_t = 1'b0;
      {s_a, s_b, init_wa, init_wb, init_bias, lr, p_force} = '0;
      {n_samples, max_epochs} = '0;
      use_model = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_wa", wa, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ready", {31'd0, s_ready}, 32'd0);
      // single mismatch: +lr*8 on both weights
      go(32'd0, 32'd0, 32'd0, 32'h0019_9999, 16'd1, 16'd1);
      check("mm_busy", {31'd0, busy}, 32'd1);
      check("mm_ready", {31'd0, s_ready}, 32'd1);
      p_force = 32'd0;
      send(32'd8, 32'd8, 1'b1, 0);
      check("mm_wait_ready", {31'd0, s_ready}, 32'd0);
      check("mm_A", A, 32'd8);
      wait_done(cyc);
      check("mm_latency", cyc, LAT + 2);
      check("mm_wa", wa, 32'h00CC_CCC8);
      check("mm_wb", wb, 32'h00CC_CCC8);
      check("mm_bias", bias, 32'h0019_9999);
      check("mm_err", {16'd0, err_cnt}, 32'd1);
      check("mm_conv", {31'd0, converged}, 32'd0);
      check("mm_busy_done", {31'd0, busy}, 32'd0);
      // match: parameters untouched
      go(32'h0010_0000, 32'hFFF0_0000, 32'h0000_0400, 32'h0019_9999, 16'd1, 16'd1);
      p_force = 32'd5;
      send(32'd8, 32'd8, 1'b1, 0);
      wait_done(cyc);
      check("match_wa", wa, 32'h0010_0000);
      check("match_wb", wb, 32'hFFF0_0000);
      check("match_bias", bias, 32'h0000_0400);
      check("match_err", {16'd0, err_cnt}, 32'd0);
      check("match_conv", {31'd0, converged}, 32'd1);
      check("match_epoch", {16'd0, epoch_cnt}, 32'd0);
      // saturation in both directions
      go(32'h7FFF_FFF0, 32'd0, 32'd0, 32'h0100_0000, 16'd1, 16'd1);
      p_force = 32'hFFFF_FFFF;
      send(32'd100, 32'd0, 1'b1, 0);
      wait_done(cyc);
      check("sat_hi_wa", wa, 32'h7FFF_FFFF);
      check("sat_hi_bias", bias, 32'h0100_0000);
      go(32'h8000_0010, 32'd0, 32'd0, 32'h0100_0000, 16'd1, 16'd1);
      p_force = 32'd5;
      send(32'd100, 32'd0, 1'b0, 0);
      wait_done(cyc);
      check("sat_lo_wa", wa, 32'h8000_0000);
      check("sat_lo_wb", wb, 32'd0);
      check("sat_lo_bias", bias, 32'hFF00_0000);
      // empty epoch finishes immediately
      go(32'd1, 32'd2, 32'd3, 32'h0100_0000, 16'd0, 16'd5);
      check("n0_done", {31'd0, done}, 32'd1);
      check("n0_conv", {31'd0, converged}, 32'd0);
      check("n0_busy", {31'd0, busy}, 32'd0);
      check("n0_wa", wa, 32'd1);
      // reset held mid-WAIT
      go(32'd5, 32'd6, 32'd7, 32'h0100_0000, 16'd1, 16'd1);
      send(32'd3, 32'd4, 1'b1, 0);
      check("rw_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      check("rw_A", A, 32'd0);
      check("rw_wa", wa, 32'd0);
      check("rw_bias", bias, 32'd0);
      check("rw_busy0", {31'd0, busy}, 32'd0);
      check("rw_ready", {31'd0, s_ready}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("rw_idle_busy", {31'd0, busy}, 32'd0);
      check("rw_idle_done", {31'd0, done}, 32'd0);
      // AND-style training, back-to-back and with gaps plus a stray start
      train(1'b0, "and");
      train(1'b1, "gap");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
